// File: rtl/divider_1hz.sv
// Free-running clock-enable generator: a single-cycle strobe every DIV clocks.
// Downstream timing logic qualifies on enable_1Hz instead of using a derived clock.
module divider_1hz #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned OUT_FREQ_HZ = 1
) (
  input  logic clock,
  input  logic reset_sync,
  output logic enable_1Hz
);

  // OUT_FREQ_HZ = 0 is mapped to DIV = 0 so it trips the check below instead of dividing by zero
  localparam int unsigned DIV   = (OUT_FREQ_HZ == 0) ? 0 : CLK_FREQ_HZ / OUT_FREQ_HZ;
  localparam int          CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TC  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  generate
    if (DIV < 1) begin : g_bad_div
      $fatal(1, "divider_1hz: DIV must be >= 1 (OUT_FREQ_HZ must be nonzero and <= CLK_FREQ_HZ)");
    end
  endgenerate

  logic [CNT_W-1:0] cnt;

  // reset_sync is an asynchronous low-true clear despite its name
  always_ff @(posedge clock or negedge reset_sync) begin
    if (!reset_sync) begin
      cnt        <= '0;
      enable_1Hz <= 1'b0;
    end else if (cnt == TC) begin
      cnt        <= '0;
      enable_1Hz <= 1'b1;
    end else begin
      cnt        <= cnt + ONE;
      enable_1Hz <= 1'b0;
    end
  end

endmodule

// File: tb/tb_divider_1hz.sv
// Directed bench for divider_1hz: DIV=10, DIV=1 and DIV=2 instances on a shared clock and reset.
module tb_divider_1hz;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en10, en1, en2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divider_1hz #(.CLK_FREQ_HZ(10), .OUT_FREQ_HZ(1)) u_div10 (
    .clock(clk), .reset_sync(rst_n), .enable_1Hz(en10));
  divider_1hz #(.CLK_FREQ_HZ(5), .OUT_FREQ_HZ(5)) u_div1 (
    .clock(clk), .reset_sync(rst_n), .enable_1Hz(en1));
  divider_1hz #(.CLK_FREQ_HZ(4), .OUT_FREQ_HZ(2)) u_div2 (
    .clock(clk), .reset_sync(rst_n), .enable_1Hz(en2));

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  // Edge k after reset release: DIV=10 strobes when k%10==0, DIV=1 is always high, DIV=2 on even k
  task automatic run_edges(input string ph, input int n);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s_div10_e%0d", ph, k), en10, (k % 10) == 0);
      chk($sformatf("%s_div1_e%0d", ph, k), en1, 1'b1);
      chk($sformatf("%s_div2_e%0d", ph, k), en2, (k % 2) == 0);
    end
  endtask

  task automatic chk_all_low(input string ph);
    chk({ph, "_div10"}, en10, 1'b0);
    chk({ph, "_div1"}, en1, 1'b0);
    chk({ph, "_div2"}, en2, 1'b0);
  endtask

  initial begin
    // Held in reset across many edges: everything stays low
    repeat (13) @(posedge clk);
    #1;
    chk_all_low("reset_hold");

    // Release between edges; strobes after edges 10, 20, 30
    @(negedge clk);
    rst_n = 1'b1;
    run_edges("first", 36);

    // Short mid-period reset pulse with the DIV=10 counter at 6, no clock edge inside it
    #1 rst_n = 1'b0;
    #2;
    chk_all_low("midpulse_async");
    #3 rst_n = 1'b1;
    run_edges("after_mid", 10);

    // en10 is high right now: reset must drop it without waiting for an edge
    chk("strobe_before_rst", en10, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_low("strobe_kill");
    repeat (2) @(posedge clk);
    #1;
    chk_all_low("strobe_kill_hold");
    @(negedge clk);
    rst_n = 1'b1;
    run_edges("after_kill", 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
